// File: rtl/sseg_src_sched.sv
// sseg_src_sched: picks what the 4-digit seven-segment display shows.
// The display can show the game timer, the remaining-mine count, or a timed
// 4-digit message. Numeric sources are clamped to 999. A serial shift-add-3
// engine then converts them to BCD, one bit per cycle.
// msg_req is a one-cycle pulse with no back-pressure. msg_hex is captured in
// the same cycle that msg_req is high. The newest request always replaces the
// message being shown.
module sseg_src_sched #(
  parameter int W        = 10,
  parameter int MSG_HOLD = 100_000_000,
  parameter int HOLD_W   = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  timer_val,
  input  logic [W-1:0]  mines_val,
  input  logic          sel_mines,
  input  logic          msg_req,
  input  logic [15:0]   msg_hex,
  output logic [3:0]    hex3,
  output logic [3:0]    hex2,
  output logic [3:0]    hex1,
  output logic [3:0]    hex0,
  output logic [1:0]    src,
  output logic          conv_busy
);

  localparam int                 CNT_W       = $clog2(W + 1);
  localparam logic [W-1:0]       CLAMP_VAL   = W'(999);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(MSG_HOLD - 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD    = CNT_W'(W);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_UPDATE = 3'd3,
    S_MSG    = 3'd4
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [W-1:0]        bin_q;
  logic [11:0]         bcd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                pend_src_q;

  logic [W-1:0]        raw_val;
  logic [W-1:0]        clamped_val;
  logic [11:0]         bcd_adj;
  logic [W+11:0]       shifted;

  // Pick the source that LOAD samples, and clamp it to 999.
  always_comb begin
    raw_val     = sel_mines ? mines_val : timer_val;
    clamped_val = (raw_val > CLAMP_VAL) ? CLAMP_VAL : raw_val;
  end

  // One double-dabble step: every nibble of 5 or more gets 3 added, then
  // {bcd, bin} shifts left by one.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. A message request preempts any conversion step.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = msg_req ? S_MSG : S_LOAD;
      S_LOAD:   state_n = msg_req ? S_MSG : S_SHIFT;
      S_SHIFT: begin
        if (msg_req) begin
          state_n = S_MSG;
        end else if (cnt_q == CNT_LAST) begin
          state_n = S_UPDATE;
        end
      end
      S_UPDATE: state_n = msg_req ? S_MSG : S_IDLE;
      S_MSG: begin
        if (!msg_req && (hold_q == '0)) begin
          state_n = S_LOAD;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Conversion datapath. A partial result left by an aborted conversion is
  // simply overwritten by the next LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pend_src_q <= 1'b0;
    end else if (state == S_LOAD) begin
      bin_q      <= clamped_val;
      bcd_q      <= '0;
      cnt_q      <= CNT_LOAD;
      pend_src_q <= sel_mines;
    end else if (state == S_SHIFT) begin
      bcd_q      <= shifted[W+11:W];
      bin_q      <= shifted[W-1:0];
      cnt_q      <= cnt_q - CNT_LAST;
    end
  end

  // Message hold counter. A request reloads it; MSG counts it down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (msg_req) begin
      hold_q <= HOLD_RELOAD;
    end else if ((state == S_MSG) && (hold_q != '0)) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  // Display registers. They change only on a message request or in UPDATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex3 <= 4'h0;
      hex2 <= 4'h0;
      hex1 <= 4'h0;
      hex0 <= 4'h0;
      src  <= 2'b00;
    end else if (msg_req) begin
      hex3 <= msg_hex[15:12];
      hex2 <= msg_hex[11:8];
      hex1 <= msg_hex[7:4];
      hex0 <= msg_hex[3:0];
      src  <= 2'b10;
    end else if (state == S_UPDATE) begin
      hex3 <= 4'h0;
      hex2 <= bcd_q[11:8];
      hex1 <= bcd_q[7:4];
      hex0 <= bcd_q[3:0];
      src  <= {1'b0, pend_src_q};
    end
  end

  assign conv_busy = (state == S_LOAD) || (state == S_SHIFT);

endmodule

// File: tb/tb_sseg_src_sched.sv
// tb_sseg_src_sched: scoreboard bench for sseg_src_sched.
// The reference model works on a cycle timeline. LOAD happens at cycle L and
// the result is visible at L+W+2. A message requested at cycle r is visible
// from r+1, and the next LOAD is at r+MSG_HOLD+1.
module tb_sseg_src_sched;

  localparam int W        = 10;
  localparam int MSG_HOLD = 20;
  localparam int HOLD_W   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  timer_val = '0;
  logic [W-1:0]  mines_val = '0;
  logic          sel_mines = 1'b0;
  logic          msg_req = 1'b0;
  logic [15:0]   msg_hex = '0;
  logic [3:0]    hex3, hex2, hex1, hex0;
  logic [1:0]    src;
  logic          conv_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Scoreboard: each entry is {hex3,hex2,hex1,hex0,src} and the cycle in
  // which it must first become visible.
  logic [17:0] exp_q[$];
  int          exp_t_q[$];

  // Reference model state.
  bit          m_in_msg;
  bit          m_pend;
  bit          m_src_p;
  int          m_r;
  int          m_next_load;
  int          m_upd;
  int          m_val;
  logic [17:0] m_last;

  // Monitor state.
  logic [17:0] mon_prev;
  logic [17:0] mon_cur;
  logic [17:0] mon_e;
  int          mon_t;

  sseg_src_sched #(
    .W        (W),
    .MSG_HOLD (MSG_HOLD),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .timer_val (timer_val),
    .mines_val (mines_val),
    .sel_mines (sel_mines),
    .msg_req   (msg_req),
    .msg_hex   (msg_hex),
    .hex3      (hex3),
    .hex2      (hex2),
    .hex1      (hex1),
    .hex0      (hex0),
    .src       (src),
    .conv_busy (conv_busy)
  );

  // Clock and cycle counter. Cycle 0 is the first cycle after reset release.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  function automatic logic [15:0] to_digits(input int v);
    int c;
    c = (v > 999) ? 999 : v;
    return {4'h0, 4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic expect_out(input logic [17:0] val, input int t);
    if (val !== m_last) begin
      exp_q.push_back(val);
      exp_t_q.push_back(t);
      m_last = val;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_t_q.delete();
    m_in_msg    = 1'b0;
    m_pend      = 1'b0;
    m_src_p     = 1'b0;
    m_r         = 0;
    m_next_load = 1;
    m_upd       = 0;
    m_val       = 0;
    m_last      = 18'h0;
  endtask

  // Advance the model by one cycle using the inputs now applied. Also check
  // conv_busy for this cycle.
  task automatic model_cycle();
    int c;
    bit busy_e;
    c = cyc;
    busy_e = !m_in_msg && ((c == m_next_load) || (m_pend && (c < m_upd)));
    checks++;
    if (conv_busy !== busy_e) begin
      errors++;
      $display("FAIL conv_busy cyc=%0d got=%b expected=%b", c, conv_busy, busy_e);
    end
    if (msg_req) begin
      m_in_msg = 1'b1;
      m_pend   = 1'b0;
      m_r      = c;
      expect_out({msg_hex, 2'b10}, c + 1);
    end else if (m_in_msg) begin
      if (c == m_r + MSG_HOLD) begin
        m_in_msg    = 1'b0;
        m_next_load = c + 1;
      end
    end else if (c == m_next_load) begin
      m_val   = sel_mines ? int'(mines_val) : int'(timer_val);
      m_src_p = sel_mines;
      m_pend  = 1'b1;
      m_upd   = c + W + 1;
    end else if (m_pend && (c == m_upd)) begin
      expect_out({to_digits(m_val), 1'b0, m_src_p}, c + 1);
      m_pend      = 1'b0;
      m_next_load = c + 2;
    end
  endtask

  // Driver: apply the inputs for one cycle at the falling edge.
  task automatic step(input bit sel, input int tv, input int mv,
                      input bit req, input logic [15:0] mh);
    @(negedge clk);
    sel_mines = sel;
    timer_val = W'(tv);
    mines_val = W'(mv);
    msg_req   = req;
    msg_hex   = mh;
    model_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(sel_mines, int'(timer_val), int'(mines_val), 1'b0, msg_hex);
  endtask

  // Assert reset between clock edges and check that the outputs clear at
  // once. Then release reset on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    msg_req = 1'b0;
    #1;
    checks++;
    if ({hex3, hex2, hex1, hex0, src, conv_busy} !== 19'h0) begin
      errors++;
      $display("FAIL async_reset got hex=%h%h%h%h src=%b busy=%b expected all zero",
               hex3, hex2, hex1, hex0, src, conv_busy);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;
    model_cycle();
  endtask

  // Monitor: every change of the displayed value must match the oldest
  // expected entry, in the exact cycle. An entry that falls due with no
  // change counts as a miss.
  always @(posedge clk) begin
    #1;
    mon_cur = {hex3, hex2, hex1, hex0, src};
    if (started && rst_n) begin
      if (mon_cur !== mon_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update cyc=%0d got=%h expected no change", cyc, mon_cur);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = exp_t_q.pop_front();
          if ((mon_e !== mon_cur) || (mon_t != cyc)) begin
            errors++;
            $display("FAIL display_update got=%h at cyc %0d expected=%h at cyc %0d",
                     mon_cur, cyc, mon_e, mon_t);
          end
        end
      end else if ((exp_t_q.size() > 0) && (exp_t_q[0] <= cyc)) begin
        checks++;
        errors++;
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        $display("FAIL missed_update cyc=%0d got=%h expected=%h from cyc %0d",
                 cyc, mon_cur, mon_e, mon_t);
      end
    end
    mon_prev = mon_cur;
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    model_reset();
    apply_reset();

    // Zero input: display stays 0, and conv_busy follows the 13-cycle loop.
    idle(28);
    // Typical value, then a value above the clamp.
    step(1'b0, 257, 0, 1'b0, 16'h0);
    idle(29);
    step(1'b0, 1000, 0, 1'b0, 16'h0);
    idle(29);
    // Mines source; sel toggles back to the timer mid-loop.
    step(1'b1, 123, 40, 1'b0, 16'h0);
    idle(20);
    step(1'b0, 123, 40, 1'b0, 16'h0);
    idle(30);
    // Message during conversion, then a second message at hold count 3.
    idle(4);
    step(1'b0, 123, 40, 1'b1, 16'hDEAD);
    idle(16);
    step(1'b0, 123, 40, 1'b1, 16'hBEEF);
    idle(40);
    // Asynchronous reset in the middle of a message.
    step(1'b0, 321, 40, 1'b1, 16'hDEAD);
    idle(8);
    apply_reset();
    idle(30);
    // Asynchronous reset in the middle of SHIFT.
    step(1'b0, 999, 40, 1'b0, 16'h0);
    idle(4);
    apply_reset();
    idle(30);

    // Random stimulus.
    for (int i = 0; i < 500; i++) begin
      bit s;
      int tv;
      int mv;
      bit rq;
      s  = ($urandom_range(0, 19) == 0) ? !sel_mines : sel_mines;
      tv = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 1023)) : int'(timer_val);
      mv = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 1023)) : int'(mines_val);
      rq = ($urandom_range(0, 39) == 0);
      step(s, tv, mv, rq, 16'($urandom_range(0, 65535)));
    end

    // Drain: every outstanding expectation must have been observed.
    idle(40);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_src_sched.md
Name: sseg_src_sched

Overview:
- Schedules what the 4-digit seven-segment display shows: game timer, remaining-mine count, or a timed 4-digit message override.
- Numeric sources are binary. They are converted to BCD by a sequential shift-add-3 engine and presented as hex3..hex0 to the display multiplexer/decoder.
- Sits between the game-logic counters and the display driver.

Parameters:
- W, 10, width of binary numeric inputs (values clamped to 999).
- MSG_HOLD, 100_000_000, message display time in clk cycles (at least 2).
- HOLD_W, 27, width of the hold counter (must satisfy 2^HOLD_W > MSG_HOLD).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- timer_val  in  W  elapsed seconds, binary.
- mines_val  in  W  remaining mines, binary.
- sel_mines  in  1  level: 1 selects mines_val, 0 selects timer_val.
- msg_req  in  1  single-cycle pulse requesting a message override.
- msg_hex  in  16  message digits {hex3,hex2,hex1,hex0}, sampled when msg_req=1.
- hex3, hex2, hex1, hex0  out  4 each  digits to the display driver, registered.
- src  out  2  source currently shown: 00 timer, 01 mines, 10 message.
- conv_busy  out  1  high while the BCD engine is in LOAD or SHIFT.

Behaviour:
- Reset (async, rst_n=0):
  - hex3..hex0 = 0.
  - src = 00.
  - conv_busy = 0.
  - FSM = IDLE, hold counter = 0, shift counter = 0.
- States: IDLE, LOAD, SHIFT, UPDATE, MSG.
- IDLE:
  - If msg_req=1, go to MSG.
  - Otherwise go to LOAD next cycle. Conversion runs continuously when no message is active.
- LOAD (1 cycle):
  - Sample source = sel_mines ? mines_val : timer_val.
  - Clamp to 999 if larger.
  - Latch sel_mines as the pending src.
  - Clear the 12-bit BCD accumulator.
  - Set shift count = W.
- SHIFT (W cycles):
  - Each cycle, add 3 to every BCD nibble that is 5 or more.
  - Then shift {bcd, bin} left 1.
  - Decrement count; leave when count reaches 0.
- UPDATE (1 cycle):
  - hex2, hex1, hex0 = hundreds, tens, units.
  - hex3 = 0.
  - src = pending src.
  - Return to IDLE.
- Latency: from the LOAD sample to the output update is W+2 cycles (12 for W=10). Outputs change only in UPDATE; intermediate BCD values are never visible.
- conv_busy = 1 exactly in LOAD and SHIFT.
- msg_req in any non-MSG state (including mid-SHIFT):
  - Abort the conversion, discarding partial results.
  - Next cycle: hex3..hex0 = msg_hex (as sampled), src = 10, hold counter = MSG_HOLD-1, enter MSG.
- MSG:
  - Decrement the hold counter each cycle.
  - When it is 0 and msg_req=0, go to LOAD. The first numeric update lands W+2 cycles later; until then the message digits remain displayed.
- msg_req while in MSG (including the same cycle the counter hits 0): latch the new msg_hex, reload the hold counter to MSG_HOLD-1, stay in MSG. The newest request always wins.
- sel_mines and value changes during SHIFT have no effect until the next LOAD.
- Boundary values:
  - Input 0 gives digits 0,0,0.
  - Inputs of 999 or more give 9,9,9.
  - No leading-zero blanking.
- rst_n asserted mid-operation: immediate return to reset values, no completion of UPDATE.

Test Plan:
- Reset then release, timer_val=0, sel_mines=0: outputs stay 0 until the first UPDATE; hex={0,0,0,0}, src=00. conv_busy pulses high for 11 cycles per 13-cycle loop.
- timer_val=257 held: after the first UPDATE, hex={0,2,5,7}. timer_val=1000 gives {0,9,9,9}. Check latency is 12 cycles from LOAD to output change.
- sel_mines=1, mines_val=40, timer_val=123: hex={0,0,4,0}, src=01. Toggle sel_mines mid-SHIFT: current result is still mines; the next loop shows {0,1,2,3}, src=00.
- msg_req pulse with msg_hex=16'hDEAD during SHIFT (MSG_HOLD=20 in TB): next cycle hex={D,E,A,D}, src=10. Held exactly 20 cycles plus 12 conversion cycles before the numeric value returns.
- Second msg_req with 16'hBEEF at hold count 3: display switches to BEEF next cycle and the hold restarts at the full 20 cycles.
- Assert rst_n=0 asynchronously mid-MSG and mid-SHIFT: outputs clear to 0 and src=00 without waiting for a clock edge; normal looping resumes after release.
